dmem_arbiter: RTL and testbench

Two-port arbiter and owner of the 16-entry x 16-bit data memory, sharing it between the processor core (store/load instructions) and an external host port (test loader / debug). Requests use a req/gnt handshake with a registered grant and a fixed one-cycle read latency. Round-robin arbitration on contention, with an optional bounded host lock for atomic multi-word transfers.

---
 rtl/dmem_arbiter.sv | 85 ++++++++
 tb/tb_dmem_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin req/gnt arbiter owning a 2^AW x DW data memory shared by core and host
// Ports: clk, sys_rst (sync, active high); core_req/we/addr/wdata and host_req/we/addr/wdata requests;
//        core_gnt/host_gnt registered grants; core_rvalid/host_rvalid one-cycle read strobes; rdata shared.
//        host_lock keeps host ownership for up to LOCK_MAX grants when DMEM_ARBITER_LOCK_EN is defined.
module dmem_arbiter #(
   parameter int AW       = 4,
   parameter int DW       = 16,
   parameter int LOCK_MAX = 8
) (
   input  logic          clk,
   input  logic          sys_rst,
   input  logic          core_req,
   input  logic          core_we,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic          core_gnt,
   output logic          core_rvalid,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   input  logic          host_lock,
   output logic          host_gnt,
   output logic          host_rvalid,
   output logic [DW-1:0] rdata
);
`ifdef DMEM_ARBITER_LOCK_EN
   typedef enum logic [1:0] {IDLE, GNT_C, GNT_H, LOCK_H} state_t;
`else
   typedef enum logic [1:0] {IDLE, GNT_C, GNT_H} state_t;
`endif
   state_t state, state_nx;
   logic last_host;
   logic host_own, hold, core_el, host_el, access, sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   logic [DW-1:0] mem [2**AW];
`ifdef DMEM_ARBITER_LOCK_EN
   localparam int CW = $clog2(LOCK_MAX + 1);
   logic [CW-1:0] cnt;
   assign host_own = state == GNT_H || state == LOCK_H;
   // cnt counts consecutive host grants including the current one
   assign hold = host_own && host_req && host_lock && cnt < CW'(LOCK_MAX);
   always_ff @(posedge clk)
      if (sys_rst) cnt <= '0;
      else cnt <= state_nx == GNT_H ? CW'(1) : state_nx == LOCK_H ? cnt + 1'b1 : '0;
`else
   localparam int unused_lock_max = LOCK_MAX;
   logic unused_lock;
   assign unused_lock = host_lock;
   assign host_own = state == GNT_H;
   assign hold = 1'b0;
`endif
   // the port granted this cycle still shows req, so it sits out the next decision
   assign core_el = core_req && state != GNT_C;
   assign host_el = host_req && !host_own;
   always_comb begin
      state_nx = core_el && (!host_el || last_host) ? GNT_C : host_el ? GNT_H : IDLE;
`ifdef DMEM_ARBITER_LOCK_EN
      if (hold) state_nx = LOCK_H;
`endif
   end
   assign core_gnt  = state == GNT_C;
   assign host_gnt  = host_own;
   assign access    = state != IDLE;
   assign sel_we    = core_gnt ? core_we : host_we;
   assign sel_addr  = core_gnt ? core_addr : host_addr;
   assign sel_wdata = core_gnt ? core_wdata : host_wdata;
   always_ff @(posedge clk)
      if (!sys_rst && access && sel_we) mem[sel_addr] <= sel_wdata;
   always_ff @(posedge clk)
      if (sys_rst) begin
         state       <= IDLE;
         last_host   <= 1'b1;
         core_rvalid <= 1'b0;
         host_rvalid <= 1'b0;
         rdata       <= '0;
      end else begin
         state       <= state_nx;
         last_host   <= core_gnt ? 1'b0 : host_gnt ? 1'b1 : last_host;
         core_rvalid <= core_gnt && !core_we;
         host_rvalid <= host_gnt && !host_we;
         if (access && !sel_we) rdata <= mem[sel_addr];
      end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
   logic        clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        core_req = 1'b0, core_we = 1'b0;
   logic [3:0]  core_addr = '0;
   logic [15:0] core_wdata = '0;
   logic        core_gnt, core_rvalid;
   logic        host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
   logic [3:0]  host_addr = '0;
   logic [15:0] host_wdata = '0;
   logic        host_gnt, host_rvalid;
   logic [15:0] rdata;
   int tests = 0;
   int failed = 0;

   dmem_arbiter #(.AW(4), .DW(16), .LOCK_MAX(8)) dut (
      .clk(clk), .sys_rst(sys_rst),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt), .core_rvalid(core_rvalid),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_lock(host_lock), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .rdata(rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic core_write(input logic [3:0] a, input logic [15:0] d);
      core_req = 1'b1; core_we = 1'b1; core_addr = a; core_wdata = d;
      tick;
      for (int n = 0; n < 10 && core_gnt !== 1'b1; n++) tick;
      tests++;
      if (core_gnt !== 1'b1) begin failed++; $display("FAIL core_write_gnt got %b exp 1", core_gnt); end
      tick;
      core_req = 1'b0; core_we = 1'b0;
   endtask

   task automatic host_write(input logic [3:0] a, input logic [15:0] d);
      host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
      tick;
      for (int n = 0; n < 10 && host_gnt !== 1'b1; n++) tick;
      tests++;
      if (host_gnt !== 1'b1) begin failed++; $display("FAIL host_write_gnt got %b exp 1", host_gnt); end
      tick;
      host_req = 1'b0; host_we = 1'b0;
   endtask

   task automatic test_reset;
      sys_rst = 1'b1; core_req = 1'b1; host_req = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick;
         tests++;
         if ({core_gnt, host_gnt, core_rvalid, host_rvalid} !== 4'b0000 || rdata !== 16'h0) begin
            failed++;
            $display("FAIL reset_hold cyc%0d got gnt/rv=%b rdata=%h exp 0000 0000", i,
                     {core_gnt, host_gnt, core_rvalid, host_rvalid}, rdata);
         end
      end
      sys_rst = 1'b0;
      tick;
      tests++;
      if ({core_gnt, host_gnt} !== 2'b10) begin
         failed++; $display("FAIL reset_release_tie got c/h=%b exp 10", {core_gnt, host_gnt});
      end
      core_req = 1'b0; host_req = 1'b0;
      tick; tick;
   endtask

   task automatic test_core_write_read;
      core_req = 1'b1; core_we = 1'b1; core_addr = 4'd3; core_wdata = 16'hBEEF;
      tick;
      tests++;
      if (core_gnt !== 1'b1) begin failed++; $display("FAIL cw_gnt got %b exp 1", core_gnt); end
      tick;
      tests++;
      if (core_gnt !== 1'b0) begin failed++; $display("FAIL cw_ineligible got %b exp 0", core_gnt); end
      core_we = 1'b0;
      tick;
      tests++;
      if ({core_gnt, core_rvalid} !== 2'b10) begin
         failed++; $display("FAIL cr_gnt got gnt/rv=%b exp 10", {core_gnt, core_rvalid});
      end
      core_req = 1'b0;
      tick;
      tests++;
      if (core_rvalid !== 1'b1 || host_rvalid !== 1'b0 || rdata !== 16'hBEEF) begin
         failed++; $display("FAIL cr_data got rv=%b hrv=%b rdata=%h exp 1 0 beef", core_rvalid, host_rvalid, rdata);
      end
      tick;
      tests++;
      if (core_rvalid !== 1'b0) begin failed++; $display("FAIL cr_pulse got %b exp 0", core_rvalid); end
   endtask

   task automatic test_contention;
      core_write(4'd1, 16'h0011);
      host_write(4'd2, 16'h0022);
      core_req = 1'b1; core_we = 1'b0; core_addr = 4'd1;
      host_req = 1'b1; host_we = 1'b0; host_addr = 4'd2;
      for (int i = 0; i < 6; i++) begin
         tick;
         tests++;
         if (core_gnt !== (i % 2 == 0) || host_gnt !== (i % 2 == 1)) begin
            failed++; $display("FAIL contend_gnt cyc%0d got c/h=%b%b exp %b%b", i, core_gnt, host_gnt,
                               i % 2 == 0, i % 2 == 1);
         end
         if (i > 0) begin
            tests++;
            if (core_rvalid !== (i % 2 == 1) || host_rvalid !== (i % 2 == 0) ||
                rdata !== ((i % 2 == 1) ? 16'h0011 : 16'h0022)) begin
               failed++; $display("FAIL contend_rd cyc%0d got rv c/h=%b%b rdata=%h exp %b%b %h", i,
                                  core_rvalid, host_rvalid, rdata, i % 2 == 1, i % 2 == 0,
                                  (i % 2 == 1) ? 16'h0011 : 16'h0022);
            end
         end
      end
      core_req = 1'b0; host_req = 1'b0;
      tick; tick;
   endtask

   task automatic test_throughput;
      int grants;
      grants = 0;
      host_req = 1'b1; host_we = 1'b0; host_addr = 4'd2;
      for (int i = 0; i < 6; i++) begin
         tick;
         if (host_gnt === 1'b1) grants++;
         tests++;
         if (host_gnt !== (i % 2 == 0)) begin
            failed++; $display("FAIL thru_gnt cyc%0d got %b exp %b", i, host_gnt, i % 2 == 0);
         end
      end
      tests++;
      if (grants != 3) begin failed++; $display("FAIL thru_count got %0d exp 3", grants); end
      host_req = 1'b0;
      tick; tick;
   endtask

   task automatic test_lock;
      logic [11:0] exp_h, exp_c;
      int idx;
      exp_h = 12'b0110_1111_1111;
      exp_c = 12'b0001_0000_0000;
      idx = 0;
      host_req = 1'b1; host_lock = 1'b1; host_we = 1'b1; host_addr = 4'd0; host_wdata = 16'h0100;
      core_we = 1'b0; core_addr = 4'd3;
      for (int i = 0; i < 12; i++) begin
         tick;
         tests++;
         if (host_gnt !== exp_h[i] || core_gnt !== exp_c[i]) begin
            failed++; $display("FAIL lock_seq cyc%0d got c/h=%b%b exp %b%b", i, core_gnt, host_gnt, exp_c[i], exp_h[i]);
         end
         if (i == 9) begin
            tests++;
            if (core_rvalid !== 1'b1 || rdata !== 16'hBEEF) begin
               failed++; $display("FAIL lock_core_rd got rv=%b rdata=%h exp 1 beef", core_rvalid, rdata);
            end
         end
         if (i == 0) core_req = 1'b1;
         if (core_gnt === 1'b1) core_req = 1'b0;
         if (host_gnt === 1'b1) begin
            idx++;
            if (idx == 10) host_req = 1'b0;
            else begin host_addr = 4'(idx); host_wdata = 16'h0100 + 16'(idx); end
         end
      end
      host_lock = 1'b0; host_we = 1'b0;
      host_req = 1'b1; host_addr = 4'd9;
      tick; tick;
      tests++;
      if (host_rvalid !== 1'b1 || rdata !== 16'h0109) begin
         failed++; $display("FAIL lock_rb9 got rv=%b rdata=%h exp 1 0109", host_rvalid, rdata);
      end
      host_addr = 4'd7;
      tick; tick;
      tests++;
      if (host_rvalid !== 1'b1 || rdata !== 16'h0107) begin
         failed++; $display("FAIL lock_rb7 got rv=%b rdata=%h exp 1 0107", host_rvalid, rdata);
      end
      host_req = 1'b0;
      tick; tick;
   endtask

   task automatic test_reset_mid;
      core_write(4'd5, 16'h1234);
      core_req = 1'b1; core_we = 1'b1; core_addr = 4'd5; core_wdata = 16'h5555;
      tick;
      tests++;
      if (core_gnt !== 1'b1) begin failed++; $display("FAIL rstw_gnt got %b exp 1", core_gnt); end
      sys_rst = 1'b1;
      tick;
      sys_rst = 1'b0; core_req = 1'b0; core_we = 1'b0;
      host_req = 1'b1; host_we = 1'b0; host_addr = 4'd2;
      tick;
      tests++;
      if (host_gnt !== 1'b1) begin failed++; $display("FAIL rstr_gnt got %b exp 1", host_gnt); end
      sys_rst = 1'b1;
      tick;
      tests++;
      if (host_rvalid !== 1'b0 || host_gnt !== 1'b0 || rdata !== 16'h0) begin
         failed++; $display("FAIL rstr_drop got rv=%b gnt=%b rdata=%h exp 0 0 0000", host_rvalid, host_gnt, rdata);
      end
      sys_rst = 1'b0; host_req = 1'b0;
      tick;
      tests++;
      if (host_rvalid !== 1'b0 || host_gnt !== 1'b0) begin
         failed++; $display("FAIL rstr_after got rv=%b gnt=%b exp 0 0", host_rvalid, host_gnt);
      end
      core_req = 1'b1; core_we = 1'b0; core_addr = 4'd5;
      tick;
      core_req = 1'b0;
      tick;
      tests++;
      if (core_rvalid !== 1'b1 || rdata !== 16'h1234) begin
         failed++; $display("FAIL rstw_nocommit got rv=%b rdata=%h exp 1 1234", core_rvalid, rdata);
      end
      tick;
   endtask

   initial begin
      test_reset;
      test_core_write_read;
      test_contention;
      test_throughput;
`ifdef DMEM_ARBITER_LOCK_EN
      test_lock;
`endif
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
